// File: rtl/rom_access_sched.sv
// Arbitrates two request lanes onto the C, Occ and read/D ROMs and returns one
// registered response per granted access. Every output comes straight from a flop.
module rom_access_sched #(
  parameter int ROM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [26:0] word0,
  input  logic [26:0] word1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        ce_rom_C,
  output logic        ce_rom_Occ,
  output logic        ce_rom_read_and_D,
  output logic [1:0]  addr_rom_C,
  output logic [7:0]  addr1_rom_Occ,
  output logic [7:0]  addr2_rom_Occ,
  output logic [7:0]  addr_rom_read_and_D,
  input  logic [7:0]  data,
  input  logic [31:0] data_1,
  input  logic [31:0] data_2,
  input  logic [7:0]  d_i,
  input  logic [1:0]  read_i,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [7:0]  rsp_C,
  output logic [7:0]  rsp_occ1,
  output logic [7:0]  rsp_occ2,
  output logic [7:0]  rsp_d,
  output logic [1:0]  rsp_read
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] LAT_M1 = 2'(ROM_LAT - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic [26:0] word_q, word_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d, busy_q, busy_d;
  logic        ce_c_q, ce_c_d, ce_occ_q, ce_occ_d, ce_rd_q, ce_rd_d;
  logic [1:0]  addr_c_q, addr_c_d;
  logic [7:0]  addr1_q, addr1_d, addr2_q, addr2_d, addr_rd_q, addr_rd_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [7:0]  rsp_c_q, rsp_c_d, rsp_occ1_q, rsp_occ1_d, rsp_occ2_q, rsp_occ2_d;
  logic [7:0]  rsp_d_q, rsp_d_d;
  logic [1:0]  rsp_read_q, rsp_read_d;

  logic        op_s, pick1_s, grant_en_s, issue_s, capture_s;
  logic [1:0]  sym_s;
  logic [7:0]  i_s, k_s, l_s;

  // Occ words pack one count byte per symbol, A in the low byte.
  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] s);
    logic [7:0] b;
    case (s)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

  assign op_s  = word_q[26];
  assign sym_s = word_q[25:24];
  assign i_s   = word_q[23:16];
  assign k_s   = word_q[15:8];
  assign l_s   = word_q[7:0];

  // Next-state, arbitration and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    id_d        = id_q;
    word_d      = word_q;
    rsp_c_d     = rsp_c_q;
    rsp_occ1_d  = rsp_occ1_q;
    rsp_occ2_d  = rsp_occ2_q;
    rsp_d_d     = rsp_d_q;
    rsp_read_d  = rsp_read_q;
    capture_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt0_q || gnt1_q) state_d = ISSUE;
        else                  state_d = IDLE;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = LAT_M1;
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d   = RESP;
          capture_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A grant is issued for the cycle the machine sits in IDLE, so arbitration
    // runs whenever the next state is IDLE (including the RESP->IDLE step).
    grant_en_s = (state_d == IDLE);
    pick1_s    = req1 && (!req0 || !last_q);
    gnt1_d     = grant_en_s && pick1_s;
    gnt0_d     = grant_en_s && req0 && !pick1_s;
    if (gnt0_d || gnt1_d) begin
      word_d = pick1_s ? word1 : word0;
      id_d   = pick1_s;
      last_d = pick1_s;
    end else begin
      word_d = word_q;
    end

    issue_s     = (state_d == ISSUE);
    ce_c_d      = issue_s && op_s;
    ce_occ_d    = issue_s && op_s;
    ce_rd_d     = issue_s && !op_s;
    addr_c_d    = ce_c_d ? sym_s : 2'd0;
    addr1_d     = ce_occ_d ? (k_s - 8'd1) : 8'd0;
    addr2_d     = ce_occ_d ? l_s : 8'd0;
    addr_rd_d   = ce_rd_d ? i_s : 8'd0;
    busy_d      = (state_d != IDLE);
    rsp_valid_d = (state_d == RESP);
    rsp_id_d    = (state_d == RESP) ? id_q : 1'b0;

    if (capture_s && op_s) begin
      rsp_c_d    = data;
      rsp_occ1_d = (k_s == 8'd0) ? 8'd0 : sel_byte(data_1, sym_s);
      rsp_occ2_d = sel_byte(data_2, sym_s);
      rsp_d_d    = 8'd0;
      rsp_read_d = 2'd0;
    end else if (capture_s) begin
      rsp_c_d    = 8'd0;
      rsp_occ1_d = 8'd0;
      rsp_occ2_d = 8'd0;
      rsp_d_d    = d_i;
      rsp_read_d = read_i;
    end else begin
      rsp_c_d    = rsp_c_q;
    end
  end

  // State, pointer and output registers; reset leaves lane 0 with priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      word_q      <= 27'd0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      busy_q      <= 1'b0;
      ce_c_q      <= 1'b0;
      ce_occ_q    <= 1'b0;
      ce_rd_q     <= 1'b0;
      addr_c_q    <= 2'd0;
      addr1_q     <= 8'd0;
      addr2_q     <= 8'd0;
      addr_rd_q   <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_c_q     <= 8'd0;
      rsp_occ1_q  <= 8'd0;
      rsp_occ2_q  <= 8'd0;
      rsp_d_q     <= 8'd0;
      rsp_read_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      id_q        <= id_d;
      word_q      <= word_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      busy_q      <= busy_d;
      ce_c_q      <= ce_c_d;
      ce_occ_q    <= ce_occ_d;
      ce_rd_q     <= ce_rd_d;
      addr_c_q    <= addr_c_d;
      addr1_q     <= addr1_d;
      addr2_q     <= addr2_d;
      addr_rd_q   <= addr_rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_c_q     <= rsp_c_d;
      rsp_occ1_q  <= rsp_occ1_d;
      rsp_occ2_q  <= rsp_occ2_d;
      rsp_d_q     <= rsp_d_d;
      rsp_read_q  <= rsp_read_d;
    end
  end

  assign gnt0                = gnt0_q;
  assign gnt1                = gnt1_q;
  assign busy                = busy_q;
  assign ce_rom_C            = ce_c_q;
  assign ce_rom_Occ          = ce_occ_q;
  assign ce_rom_read_and_D   = ce_rd_q;
  assign addr_rom_C          = addr_c_q;
  assign addr1_rom_Occ       = addr1_q;
  assign addr2_rom_Occ       = addr2_q;
  assign addr_rom_read_and_D = addr_rd_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_id              = rsp_id_q;
  assign rsp_C               = rsp_c_q;
  assign rsp_occ1            = rsp_occ1_q;
  assign rsp_occ2            = rsp_occ2_q;
  assign rsp_d               = rsp_d_q;
  assign rsp_read            = rsp_read_q;

endmodule

// File: doc/rom_access_sched.md
ROM_ACCESS_SCHED -- requirements
Module: rom_access_sched

Interface
REQ-001 SHALL have parameter ROM_LAT, default 1, meaning ROM read latency in cycles from ce-high cycle to data valid; legal range 1..3.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: one clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports req0 and req1, input, 1 each, request from lane 0 and lane 1, held high until granted.
REQ-005 SHALL have ports word0 and word1, input, 27 each, request descriptor {op[26], sym[25:24], i[23:16], k[15:8], l[7:0]}; op=1 C/Occ lookup, op=0 D/read lookup; sym 00=A, 01=C, 10=G, 11=T.
REQ-006 SHALL have ports gnt0 and gnt1, output, 1 each, one-cycle grant pulses.
REQ-007 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 SHALL have ports ce_rom_C, ce_rom_Occ, ce_rom_read_and_D, output, 1 each, ROM enables.
REQ-009 SHALL have ports addr_rom_C (2), addr1_rom_Occ (8), addr2_rom_Occ (8), addr_rom_read_and_D (8), outputs, ROM addresses.
REQ-010 SHALL have ROM data inputs data (8, rom_C), data_1 (32), data_2 (32, rom_Occ), d_i (8), read_i (2, rom_read_and_D).
REQ-011 SHALL have outputs rsp_valid (1), rsp_id (1), rsp_C (8), rsp_occ1 (8), rsp_occ2 (8), rsp_d (8), rsp_read (2), the response to the granted lane.

Function
REQ-012 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; every output registered.
REQ-013 In IDLE with any req high, SHALL pulse exactly one gnt, latch that lane's word and id, and enter ISSUE next cycle.
REQ-014 Arbitration SHALL be round-robin: single requester wins; both requesting -> lane not served last wins; after reset lane 0 has priority.
REQ-015 Requests SHALL be ignored outside IDLE; gnt SHALL never assert outside IDLE.
REQ-016 ISSUE (one cycle), op=1: ce_rom_C=ce_rom_Occ=1, addr_rom_C=sym, addr1_rom_Occ=k-1 (mod 256), addr2_rom_Occ=l, ce_rom_read_and_D=0.
REQ-017 ISSUE, op=0: ce_rom_read_and_D=1, addr_rom_read_and_D=i, other enables 0.
REQ-018 Outside ISSUE all ROM enables and addresses SHALL be 0.
REQ-019 WAIT SHALL last ROM_LAT cycles via down-counter; on its last cycle SHALL capture ROM data into rsp fields.
REQ-020 op=1 capture: rsp_C=data, rsp_occ1/rsp_occ2 = byte sym of data_1/data_2 (sym 0 -> [7:0] ... sym 3 -> [31:24]); rsp_d, rsp_read = 0.
REQ-021 op=1 with k=0: address SHALL wrap to 255, and rsp_occ1 SHALL be forced to 0 (Occ(-1)=0).
REQ-022 op=0 capture: rsp_d=d_i, rsp_read=read_i; rsp_C, rsp_occ1, rsp_occ2 = 0.
REQ-023 RESP SHALL assert rsp_valid for exactly one cycle with rsp_id = granted lane; rsp data fields hold until next capture.
REQ-024 Latency: gnt at cycle t -> rsp_valid at cycle t+2+ROM_LAT; next gnt earliest t+3+ROM_LAT.
REQ-025 Requester deasserting req after gnt SHALL not affect the in-flight access.

Reset
REQ-026 rst high SHALL immediately force IDLE, all outputs 0, WAIT counter 0, round-robin pointer to lane-0 priority.
REQ-027 rst asserted mid-access SHALL drop the access with no rsp_valid; first grant after release obeys REQ-014.

Verification
REQ-028 ROM_LAT=1, req0 only, op=1 sym=C k=5 l=9 -> gnt0 at t, ISSUE t+1 with addr_rom_C=1, addr1=4, addr2=9; rsp_valid at t+3, rsp_occ1=data_1[15:8].
REQ-029 req0 and req1 held continuously, op=0 -> grants alternate 0,1,0,1; rsp_id alternates; gnt spacing 4 cycles.
REQ-030 op=1 k=0 l=0 sym=T -> addr1_rom_Occ=255, rsp_occ1=0, rsp_occ2=data_2[31:24].
REQ-031 ROM_LAT=3, op=0 i=0x2A -> addr_rom_read_and_D=0x2A in ISSUE only; rsp_d=d_i, rsp_read=read_i at t+5.
REQ-032 rst pulsed during WAIT -> no rsp_valid, all outputs 0; with both req high after release -> gnt0 first.
